sipo_rx_ctrl: RTL and testbench

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_rx_ctrl_if.sv | 29 ++
 rtl/sipo_shift.sv | 54 +++++
 rtl/sipo_rx_ctrl.sv | 124 ++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and default sizing for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int GAP_MAX_DEF = 255;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Control, serial-input and output-buffer signals of the SIPO receiver.
// The slave modport is the receiver; the master modport is whoever drives it.
interface sipo_rx_ctrl_if #(
  parameter int DATA_W = sipo_pkg::DATA_W_DEF
);

  logic              start;
  logic              abort;
  logic              bit_valid;
  logic              serial_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              clr_ovr;
  logic              timeout;

  modport master (
    output start, abort, bit_valid, serial_in, out_ready, clr_ovr,
    input  out_data, out_valid, busy, overrun, timeout
  );

  modport slave (
    input  start, abort, bit_valid, serial_in, out_ready, clr_ovr,
    output out_data, out_valid, busy, overrun, timeout
  );

endinterface

// File: rtl/sipo_shift.sv
// Shift register plus bit counter. The first bit shifted in ends up in the
// MSB. done strobes on the shift that completes a word; word is the completed
// value including the bit being shifted in that cycle.
module sipo_shift #(
  parameter int DATA_W = sipo_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              done
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign word = {sr_q[DATA_W-2:0], bit_in};

  // Next shift-register / bit-count value; count resets on completion so it never wraps
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[DATA_W-2:0], bit_in};
      if (cnt_q == CNT_LAST) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out receive controller: frame FSM, inter-bit gap timer
// and a single-entry output buffer with sticky overrun.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; bit_valid and abort are ignored
//   ST_SHIFT | collecting bits; leaves on word completion, abort or gap timeout
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  sipo_rx_ctrl_if.slave bus
);

  localparam int               GAP_W    = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              sh_clr;
  logic              sh_en;
  logic              sh_done;
  logic [DATA_W-1:0] sh_word;
  logic              ovr_set;

  // Abort outranks a bit arriving in the same cycle, so it suppresses the shift
  assign sh_clr = (state_q == ST_IDLE) && bus.start;
  assign sh_en  = (state_q == ST_SHIFT) && bus.bit_valid && !bus.abort;

  sipo_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .bit_in   (bus.serial_in),
    .word     (sh_word),
    .done     (sh_done)
  );

  // Frame FSM and gap timer; reaching GAP_MAX idle cycles ends the frame like an abort
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          gap_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else if (bus.bit_valid) begin
          gap_d = '0;
          if (sh_done) state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_d     = '0;
          timeout_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed word is dropped only when the buffer is full and not being read this cycle
  assign ovr_set = sh_done && valid_q && !bus.out_ready;

  // Single-entry output buffer; a read and a load in the same cycle keep valid high
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    if (sh_done && (!valid_q || bus.out_ready)) begin
      data_d  = sh_word;
      valid_d = 1'b1;
    end
    if (ovr_set)          ovr_d = 1'b1;
    else if (bus.clr_ovr) ovr_d = 1'b0;
    else                  ovr_d = ovr_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      timeout_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.overrun   = ovr_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl (DATA_W=8, GAP_MAX=4).
module tb_sipo_rx_ctrl;

  localparam int DW = 8;
  localparam int GM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sipo_rx_ctrl_if #(.DATA_W(DW)) bus();

  sipo_rx_ctrl #(
    .DATA_W  (DW),
    .GAP_MAX (GM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] sb_req;

  typedef struct {
    logic [DW-1:0] word;
    int            gap;
    int            abort_at;
    logic          req_valid;
    logic [DW-1:0] req_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; abort_at selects the bit index that also carries abort (-1: none)
  task automatic send_frame(input logic [DW-1:0] w, input int gap, input int abort_at,
                            input logic ready_last, input logic clr_last);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < DW; i++) begin
      repeat (gap) tick;
      bus.bit_valid = 1'b1;
      bus.serial_in = w[DW-1-i];
      if (i == abort_at) bus.abort = 1'b1;
      if (i == DW - 1 && ready_last) bus.out_ready = 1'b1;
      if (i == DW - 1 && clr_last) bus.clr_ovr = 1'b1;
      tick;
      bus.bit_valid = 1'b0;
      bus.abort     = 1'b0;
      bus.clr_ovr   = 1'b0;
      if (i == abort_at) break;
    end
  endtask

  // Scoreboard: every word the consumer accepts must match the oldest expected word
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %0h, required no word", bus.out_data);
      end else begin
        sb_req = sb_q.pop_front();
        chk("sb_word", {24'd0, bus.out_data}, {24'd0, sb_req});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hB2, 0, -1, 1'b1, 8'hB2};
    vecs[1] = '{8'h00, 1, -1, 1'b1, 8'h00};
    vecs[2] = '{8'hFF, 3, -1, 1'b1, 8'hFF};
    vecs[3] = '{8'h5A, 2,  7, 1'b0, 8'h00};
    vecs[4] = '{8'h81, 0,  3, 1'b0, 8'h00};
    vecs[5] = '{8'h7E, 1, -1, 1'b1, 8'h7E};

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovr   = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (2) tick;
    chk("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_overrun",   {31'd0, bus.overrun}, 32'd0);
    chk("rst_timeout",   {31'd0, bus.timeout}, 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick;

    // Table-driven frames with the consumer always ready
    foreach (vecs[k]) begin
      if (vecs[k].req_valid) sb_q.push_back(vecs[k].req_data);
      send_frame(vecs[k].word, vecs[k].gap, vecs[k].abort_at, 1'b0, 1'b0);
      chk("vec_busy_end", {31'd0, bus.busy}, 32'd0);
      chk("vec_out_valid", {31'd0, bus.out_valid}, {31'd0, vecs[k].req_valid});
      if (vecs[k].req_valid)
        chk("vec_out_data", {24'd0, bus.out_data}, {24'd0, vecs[k].req_data});
    end
    tick;

    // Backpressure: second word dropped, overrun set, then cleared
    bus.out_ready = 1'b0;
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 0, -1, 1'b0, 1'b0);
    send_frame(8'h3C, 1, -1, 1'b0, 1'b0);
    chk("bp_out_data",  {24'd0, bus.out_data}, 32'hA5);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_overrun",   {31'd0, bus.overrun}, 32'd1);
    bus.clr_ovr = 1'b1;
    tick;
    bus.clr_ovr = 1'b0;
    chk("bp_clr_ovr", {31'd0, bus.overrun}, 32'd0);

    // clr_ovr coinciding with a new drop: set wins
    send_frame(8'h3C, 0, -1, 1'b0, 1'b1);
    chk("bp_set_wins", {31'd0, bus.overrun}, 32'd1);
    chk("bp_hold_data", {24'd0, bus.out_data}, 32'hA5);
    bus.clr_ovr = 1'b1;
    tick;
    bus.clr_ovr = 1'b0;
    chk("bp_clr_again", {31'd0, bus.overrun}, 32'd0);

    // Same-cycle handoff: 3C completes while A5 is consumed
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 0, -1, 1'b1, 1'b0);
    chk("ho_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("ho_out_data",  {24'd0, bus.out_data}, 32'h3C);
    chk("ho_overrun",   {31'd0, bus.overrun}, 32'd0);
    tick;
    chk("ho_drained", {31'd0, bus.out_valid}, 32'd0);

    // Gap timeout with a word held in the buffer
    bus.out_ready = 1'b0;
    sb_q.push_back(8'h96);
    send_frame(8'h96, 0, -1, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = i[0];
      tick;
    end
    bus.bit_valid = 1'b0;
    repeat (3) tick;
    chk("to_not_yet", {31'd0, bus.timeout}, 32'd0);
    chk("to_busy_pre", {31'd0, bus.busy}, 32'd1);
    tick;
    chk("to_pulse",     {31'd0, bus.timeout}, 32'd1);
    chk("to_busy",      {31'd0, bus.busy}, 32'd0);
    chk("to_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("to_out_data",  {24'd0, bus.out_data}, 32'h96);
    tick;
    chk("to_one_cycle", {31'd0, bus.timeout}, 32'd0);
    bus.out_ready = 1'b1;
    tick;

    // Reset mid-frame discards both the partial and the buffered word
    bus.out_ready = 1'b0;
    send_frame(8'h11, 0, -1, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = 1'b1;
      tick;
    end
    bus.bit_valid = 1'b0;
    rst = 1'b0;
    tick;
    chk("mr_out_data",  {24'd0, bus.out_data}, 32'd0);
    chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_busy",      {31'd0, bus.busy}, 32'd0);
    chk("mr_overrun",   {31'd0, bus.overrun}, 32'd0);
    chk("mr_timeout",   {31'd0, bus.timeout}, 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    sb_q.push_back(8'hFF);
    send_frame(8'hFF, 0, -1, 1'b0, 1'b0);
    chk("mr_next_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mr_next_data",  {24'd0, bus.out_data}, 32'hFF);
    repeat (2) tick;

    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
